// File: rtl/calc1_router_pkg.sv
// calc1 result router: shared constants, queue entry type and helpers.
// Response codes and the id-to-port mapping live here for all router files.
package calc1_router_pkg;

    localparam int RES_DATA_W = 32;
    localparam int NUM_PORTS  = 4;

    localparam logic [0:1] RESP_NONE = 2'b00;
    localparam logic [0:1] RESP_OK   = 2'b01;
    localparam logic [0:1] RESP_OVF  = 2'b10;
    localparam logic [0:1] RESP_INV  = 2'b11;

    typedef struct packed {
        logic [0:1]            id;
        logic [0:1]            resp;
        logic [0:RES_DATA_W-1] data;
    } res_entry_t;

    // Request id 00..11 selects requester port 1..4 (index 0..3).
    function automatic logic [1:0] id_to_port(input logic [0:1] id);
        return id;
    endfunction

endpackage

// File: rtl/calc1_result_router_if.sv
// calc1 result router bus: ALU result inputs and per-port response outputs.
// master = ALU/requester side, slave = router.
interface calc1_result_router_if #(
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic              alu1_out_vld;
    logic [0:1]        alu1_out_req_id;
    logic [0:1]        alu1_out_resp;
    logic [0:DATA_W-1] alu1_out_data;
    logic              alu2_out_vld;
    logic [0:1]        alu2_out_req_id;
    logic [0:1]        alu2_out_resp;
    logic [0:DATA_W-1] alu2_out_data;

    logic [0:1]        out_resp1;
    logic [0:1]        out_resp2;
    logic [0:1]        out_resp3;
    logic [0:1]        out_resp4;
    logic [0:DATA_W-1] out_data1;
    logic [0:DATA_W-1] out_data2;
    logic [0:DATA_W-1] out_data3;
    logic [0:DATA_W-1] out_data4;
    logic [0:CW-1]     pend_cnt;
    logic              router_overflow;
    logic              router_busy;

    modport master (
        output alu1_out_vld, alu1_out_req_id, alu1_out_resp, alu1_out_data,
        output alu2_out_vld, alu2_out_req_id, alu2_out_resp, alu2_out_data,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4,
        input  pend_cnt, router_overflow, router_busy
    );

    modport slave (
        input  alu1_out_vld, alu1_out_req_id, alu1_out_resp, alu1_out_data,
        input  alu2_out_vld, alu2_out_req_id, alu2_out_resp, alu2_out_data,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4,
        output pend_cnt, router_overflow, router_busy
    );

endinterface

// File: rtl/calc1_result_queue.sv
// Pending-result FIFO: two ordered pushes and one pop per cycle.
// Full/empty come from the count; pointers simply wrap modulo QDEPTH.
module calc1_result_queue
    import calc1_router_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push0,
    input  res_entry_t                   ent0,
    input  logic                         push1,
    input  res_entry_t                   ent1,
    input  logic                         pop,
    output logic [$clog2(QDEPTH):0]      count,
    output res_entry_t                   head
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    res_entry_t    mem_q [QDEPTH];
    res_entry_t    mem_d [QDEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok;

    // Write entries in push order, advance pointers, update occupancy.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        pop_ok = pop && (cnt_q != '0);
        if (push0) begin
            mem_d[wr_d] = ent0;
            wr_d        = wr_d + AW'(1);
        end
        if (push1) begin
            mem_d[wr_d] = ent1;
            wr_d        = wr_d + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push0) + CW'(push1) - CW'(pop_ok);
    end

    // Storage, pointers and count; reset discards all pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/calc1_result_router.sv
// calc1 return path: routes ALU1/ALU2 results to requester ports.
// Colliding results queue up; per-port order follows completion order.
module calc1_result_router
    import calc1_router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
) (
    input  logic                  c_clk,
    input  logic                  reset_n,
    calc1_result_router_if.slave  bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    res_entry_t        ent1, ent2, head;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     free;
    logic [1:0]        p1, p2, pp;
    logic              pop, v1, v2, dir1, dir2;
    logic              enq1, enq2, acc1, acc2, drop;
    logic [CW-1:0]     pcnt_q [NUM_PORTS];
    logic [CW-1:0]     pcnt_d [NUM_PORTS];
    logic [0:1]        resp_q [NUM_PORTS];
    logic [0:1]        resp_d [NUM_PORTS];
    logic [0:DATA_W-1] data_q [NUM_PORTS];
    logic [0:DATA_W-1] data_d [NUM_PORTS];
    logic              ovf_q, ovf_d;

    // Resolve pop, direct paths and enqueues in fixed priority order.
    always_comb begin
        ent1.id   = bus.alu1_out_req_id;
        ent1.resp = bus.alu1_out_resp;
        ent1.data = bus.alu1_out_data;
        ent2.id   = bus.alu2_out_req_id;
        ent2.resp = bus.alu2_out_resp;
        ent2.data = bus.alu2_out_data;
        p1   = id_to_port(ent1.id);
        p2   = id_to_port(ent2.id);
        pp   = id_to_port(head.id);
        pop  = (cnt != '0);
        v1   = bus.alu1_out_vld && (ent1.resp != RESP_NONE);
        v2   = bus.alu2_out_vld && (ent2.resp != RESP_NONE);
        dir1 = v1 && !(pop && pp == p1) && (pcnt_q[p1] == '0);
        enq1 = v1 && !dir1;
        dir2 = v2 && !(pop && pp == p2) && !(dir1 && p1 == p2)
               && (pcnt_q[p2] == '0);
        enq2 = v2 && !dir2;
        free = CW'(QDEPTH) - cnt + CW'(pop);
        acc1 = enq1 && (free != '0);
        acc2 = enq2 && (free > CW'(acc1));
        drop = (enq1 && !acc1) || (enq2 && !acc2);
    end

    // Next per-port outputs, pending counters and sticky overflow.
    always_comb begin
        ovf_d = ovf_q | drop;
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_d[p] = RESP_NONE;
            data_d[p] = '0;
            pcnt_d[p] = pcnt_q[p]
                      + CW'(acc1 && p1 == 2'(p))
                      + CW'(acc2 && p2 == 2'(p))
                      - CW'(pop && pp == 2'(p));
        end
        if (pop) begin
            resp_d[pp] = head.resp;
            data_d[pp] = head.data;
        end
        if (dir1) begin
            resp_d[p1] = ent1.resp;
            data_d[p1] = ent1.data;
        end
        if (dir2) begin
            resp_d[p2] = ent2.resp;
            data_d[p2] = ent2.data;
        end
    end

    // Registered outputs and counters, cleared asynchronously.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                data_q[p] <= '0;
                pcnt_q[p] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            resp_q <= resp_d;
            data_q <= data_d;
            pcnt_q <= pcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    calc1_result_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (c_clk),
        .rst_n (reset_n),
        .push0 (acc1),
        .ent0  (ent1),
        .push1 (acc2),
        .ent1  (ent2),
        .pop   (pop),
        .count (cnt),
        .head  (head)
    );

    assign bus.out_resp1       = resp_q[0];
    assign bus.out_resp2       = resp_q[1];
    assign bus.out_resp3       = resp_q[2];
    assign bus.out_resp4       = resp_q[3];
    assign bus.out_data1       = data_q[0];
    assign bus.out_data2       = data_q[1];
    assign bus.out_data3       = data_q[2];
    assign bus.out_data4       = data_q[3];
    assign bus.pend_cnt        = cnt;
    assign bus.router_overflow = ovf_q;
    assign bus.router_busy     = (cnt != '0);

endmodule

// File: tb/tb_calc1_result_router.sv
// Scoreboard bench for calc1_result_router: directed vectors push expected
// per-port responses with arrival cycle; a negedge monitor pops and compares.
module tb_calc1_result_router;

    logic c_clk   = 1'b0;
    logic reset_n = 1'b0;

    always #5 c_clk = ~c_clk;

    calc1_result_router_if #(.DATA_W(32), .QDEPTH(4)) bus ();

    calc1_result_router #(.DATA_W(32), .QDEPTH(4)) dut (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        int          stamp;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   base  = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    // Monitor: every presented response must be the oldest expected one
    // for that port, with the expected code, data and arrival cycle.
    always @(negedge c_clk) begin
        logic [1:0]  r [4];
        logic [31:0] d [4];
        int          idx;
        r[0] = bus.out_resp1; r[1] = bus.out_resp2;
        r[2] = bus.out_resp3; r[3] = bus.out_resp4;
        d[0] = bus.out_data1; d[1] = bus.out_data2;
        d[2] = bus.out_data3; d[3] = bus.out_data4;
        for (int p = 0; p < 4; p++) begin
            if (r[p] != 2'b00) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].port == p) idx = i;
                tests++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL unexpected_port%0d got resp=%b data=%h cyc=%0d need none",
                             p + 1, r[p], d[p], cyc);
                end else begin
                    if (r[p] !== sb[idx].resp || d[p] !== sb[idx].data ||
                        cyc != sb[idx].stamp) begin
                        fails++;
                        $display("FAIL port%0d_out got resp=%b data=%h cyc=%0d need resp=%b data=%h cyc=%0d",
                                 p + 1, r[p], d[p], cyc,
                                 sb[idx].resp, sb[idx].data, sb[idx].stamp);
                    end
                    sb.delete(idx);
                end
            end else if (d[p] != 32'h0) begin
                tests++;
                fails++;
                $display("FAIL idle_data_port%0d got %h need 0", p + 1, d[p]);
            end
        end
    end

    task automatic clr_in();
        bus.alu1_out_vld = 1'b0; bus.alu1_out_req_id = 2'b00;
        bus.alu1_out_resp = 2'b00; bus.alu1_out_data = 32'h0;
        bus.alu2_out_vld = 1'b0; bus.alu2_out_req_id = 2'b00;
        bus.alu2_out_resp = 2'b00; bus.alu2_out_data = 32'h0;
    endtask

    task automatic tick();
        @(negedge c_clk);
        base = cyc;
        clr_in();
    endtask

    task automatic set_in(input logic v1, input logic [1:0] i1,
                          input logic [1:0] r1, input logic [31:0] d1,
                          input logic v2, input logic [1:0] i2,
                          input logic [1:0] r2, input logic [31:0] d2);
        bus.alu1_out_vld = v1; bus.alu1_out_req_id = i1;
        bus.alu1_out_resp = r1; bus.alu1_out_data = d1;
        bus.alu2_out_vld = v2; bus.alu2_out_req_id = i2;
        bus.alu2_out_resp = r2; bus.alu2_out_data = d2;
    endtask

    task automatic push_exp(input int port, input logic [1:0] r,
                            input logic [31:0] d, input int dly);
        sb.push_back('{port, r, d, base + dly});
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s got %0d need %0d", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr_in();
        repeat (2) @(negedge c_clk);
        chk("rst_pend", int'(bus.pend_cnt), 0);
        chk("rst_ovf", int'(bus.router_overflow), 0);
        chk("rst_busy", int'(bus.router_busy), 0);
        chk("rst_resp1", int'(bus.out_resp1), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // single result to port2
        tick();
        set_in(1, 2'b01, 2'b01, 32'h5, 0, 2'b00, 2'b00, 32'h0);
        push_exp(1, 2'b01, 32'h5, 1);
        tick();
        chk("single_pend", int'(bus.pend_cnt), 0);
        repeat (2) tick();

        // same-port collision on port3
        tick();
        set_in(1, 2'b10, 2'b01, 32'hA, 1, 2'b10, 2'b01, 32'hB);
        push_exp(2, 2'b01, 32'hA, 1);
        push_exp(2, 2'b01, 32'hB, 2);
        tick();
        chk("coll_pend_t1", int'(bus.pend_cnt), 1);
        chk("coll_busy_t1", int'(bus.router_busy), 1);
        tick();
        chk("coll_pend_t2", int'(bus.pend_cnt), 0);
        repeat (2) tick();

        // ordering across cycles
        tick();
        set_in(1, 2'b00, 2'b01, 32'hA1, 1, 2'b00, 2'b01, 32'hB2);
        push_exp(0, 2'b01, 32'hA1, 1);
        push_exp(0, 2'b01, 32'hB2, 2);
        tick();
        set_in(1, 2'b00, 2'b01, 32'hC3, 1, 2'b01, 2'b01, 32'hD4);
        push_exp(0, 2'b01, 32'hC3, 2);
        push_exp(1, 2'b01, 32'hD4, 1);
        repeat (4) tick();
        chk("order_pend", int'(bus.pend_cnt), 0);

        // invalid (resp=00) ignored; codes 10/11 routed
        tick();
        set_in(1, 2'b00, 2'b00, 32'h77, 1, 2'b11, 2'b00, 32'h88);
        tick();
        chk("inv_pend", int'(bus.pend_cnt), 0);
        set_in(1, 2'b11, 2'b10, 32'h1234, 1, 2'b01, 2'b11, 32'h9);
        push_exp(3, 2'b10, 32'h1234, 1);
        push_exp(1, 2'b11, 32'h9, 1);
        repeat (3) tick();

        // overflow: both ALUs to port4 for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i > 0) begin
                chk($sformatf("ovf_pend_%0d", i), int'(bus.pend_cnt), i);
                chk($sformatf("ovf_clear_%0d", i), int'(bus.router_overflow), 0);
            end
            if (i == 0) begin
                for (int j = 0; j < 5; j++) begin
                    push_exp(3, 2'b01, 32'hA0 + j, 2 * j + 1);
                    if (j < 4) push_exp(3, 2'b01, 32'hB0 + j, 2 * j + 2);
                end
            end
            set_in(1, 2'b11, 2'b01, 32'hA0 + i, 1, 2'b11, 2'b01, 32'hB0 + i);
        end
        tick();
        chk("ovf_pend_full", int'(bus.pend_cnt), 4);
        chk("ovf_set", int'(bus.router_overflow), 1);
        repeat (10) tick();
        chk("ovf_drain_pend", int'(bus.pend_cnt), 0);
        chk("ovf_sticky", int'(bus.router_overflow), 1);
        chk("ovf_drain_busy", int'(bus.router_busy), 0);

        // reset mid-operation with pend_cnt=3
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                push_exp(3, 2'b01, 32'hC0, 1);
                push_exp(3, 2'b01, 32'hD0, 2);
                push_exp(3, 2'b01, 32'hC1, 3);
            end
            set_in(1, 2'b11, 2'b01, 32'hC0 + i, 1, 2'b11, 2'b01, 32'hD0 + i);
        end
        tick();
        chk("mid_pend", int'(bus.pend_cnt), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pend", int'(bus.pend_cnt), 0);
        chk("arst_ovf", int'(bus.router_overflow), 0);
        chk("arst_resp4", int'(bus.out_resp4), 0);
        chk("arst_data4", int'(bus.out_data4), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        set_in(0, 2'b00, 2'b00, 32'h0, 1, 2'b00, 2'b01, 32'h42);
        push_exp(0, 2'b01, 32'h42, 1);
        repeat (3) tick();
        chk("post_pend", int'(bus.pend_cnt), 0);
        chk("sb_left", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
